fifo_sc8x8: RTL and testbench



---
 rtl/fifo_sc_pkg.sv | 15 +
 rtl/fifo_sc8x8_if.sv | 33 +++
 rtl/fifo_sc_mem.sv | 22 ++
 rtl/fifo_sc8x8.sv | 79 +++++++
 tb/tb_fifo_sc8x8.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_sc_pkg.sv
// Shared sizing and threshold defaults for the 8x8 single-clock FIFO.
package fifo_sc_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int AFULL_TH  = 7;
  localparam int AEMPTY_TH = 1;

  // count needs one extra bit so that "full" (DEPTH) is distinct from "empty" (0)
  typedef logic [ADDR_W:0]   count_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_sc8x8_if.sv
// Producer/consumer bus of the 8x8 FIFO with dcfifo-style duplicated status views.
interface fifo_sc8x8_if;
  import fifo_sc_pkg::*;

  logic       wrreq;
  word_t      data;
  logic       wrempty;
  logic       wrfull;
  logic       wr_almost_empty;
  logic       wr_almost_full;
  ptr_t       wrusedw;

  logic       rdreq;
  word_t      q;
  logic       rdempty;
  logic       rdfull;
  logic       rd_almost_empty;
  logic       rd_almost_full;
  ptr_t       rdusedw;

  modport master (
    output wrreq, data, rdreq,
    input  wrempty, wrfull, wr_almost_empty, wr_almost_full, wrusedw,
    input  q, rdempty, rdfull, rd_almost_empty, rd_almost_full, rdusedw
  );

  modport slave (
    input  wrreq, data, rdreq,
    output wrempty, wrfull, wr_almost_empty, wr_almost_full, wrusedw,
    output q, rdempty, rdfull, rd_almost_empty, rd_almost_full, rdusedw
  );

endinterface

// File: rtl/fifo_sc_mem.sv
// Simple dual-port register array: synchronous write, combinational read address port.
module fifo_sc_mem
  import fifo_sc_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  ptr_t  waddr,
  input  word_t wdata,
  input  ptr_t  raddr,
  output word_t rdata
);

  word_t mem [DEPTH];

  // storage is intentionally not reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sc8x8.sv
// Single-clock 8-word x 8-bit FIFO with duplicated write/read status views.
// Build option: define FIFO_SHOWAHEAD_EN for show-ahead read mode (q shows the
// head word continuously, rdreq pops it). Default is normal mode (q is
// registered and updates the cycle after an accepted read).
module fifo_sc8x8
  import fifo_sc_pkg::*;
(
  input  logic         clk,
  input  logic         aclr_n,
  fifo_sc8x8_if.slave  bus
);

  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  count_t count;
  word_t  mem_rdata;

  logic empty, full, almost_empty, almost_full;
  logic wr_ok, rd_ok;

  assign empty        = (count == '0);
  assign full         = (count == count_t'(DEPTH));
  assign almost_empty = (count <= count_t'(AEMPTY_TH));
  assign almost_full  = (count >= count_t'(AFULL_TH));

  // full gates writes unconditionally, so a write is rejected at full even when a read pops
  assign wr_ok = bus.wrreq & ~full;
  assign rd_ok = bus.rdreq & ~empty;

  fifo_sc_mem u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ptr_t'(1);
      if (wr_ok && !rd_ok)      count <= count + count_t'(1);
      else if (rd_ok && !wr_ok) count <= count - count_t'(1);
    end
  end

`ifdef FIFO_SHOWAHEAD_EN
  assign bus.q = mem_rdata;
`else
  word_t q_reg;

  // normal mode: q captures the head word on an accepted read and holds otherwise
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)    q_reg <= '0;
    else if (rd_ok) q_reg <= mem_rdata;
  end

  assign bus.q = q_reg;
`endif

  assign bus.wrempty         = empty;
  assign bus.wrfull          = full;
  assign bus.wr_almost_empty = almost_empty;
  assign bus.wr_almost_full  = almost_full;
  assign bus.wrusedw         = count[ADDR_W-1:0];

  assign bus.rdempty         = empty;
  assign bus.rdfull          = full;
  assign bus.rd_almost_empty = almost_empty;
  assign bus.rd_almost_full  = almost_full;
  assign bus.rdusedw         = count[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_sc8x8.sv
// Directed self-checking bench for fifo_sc8x8 (default normal read mode).
module tb_fifo_sc8x8;

  logic clk;
  logic aclr_n;
  int   checks;
  int   errors;

  fifo_sc8x8_if bus();

  fifo_sc8x8 dut (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance one edge and settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    aclr_n    = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    bus.data  = 8'h00;
    #12;
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if ({bus.wrempty, bus.rdempty, bus.wr_almost_empty, bus.rd_almost_empty} !== 4'b1111) begin
        errors++;
        $display("FAIL reset_empty pass%0d: got %b want 1111", pass,
                 {bus.wrempty, bus.rdempty, bus.wr_almost_empty, bus.rd_almost_empty});
      end
      checks++;
      if ({bus.wrfull, bus.rdfull, bus.wr_almost_full, bus.rd_almost_full} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_full pass%0d: got %b want 0000", pass,
                 {bus.wrfull, bus.rdfull, bus.wr_almost_full, bus.rd_almost_full});
      end
      checks++;
      if ({bus.wrusedw, bus.rdusedw, bus.q} !== 14'h0) begin
        errors++;
        $display("FAIL reset_usedw_q pass%0d: got wr=%0d rd=%0d q=%h want 0 0 00", pass,
                 bus.wrusedw, bus.rdusedw, bus.q);
      end
      if (pass == 0) begin
        @(posedge clk);
        #1;
        aclr_n = 1'b1;
        repeat (5) cyc();
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      bus.wrreq = 1'b1;
      bus.data  = 8'(i);
      cyc();
      checks++;
      if (bus.wrusedw !== 3'((i + 1) % 8) || bus.rdusedw !== 3'((i + 1) % 8)) begin
        errors++;
        $display("FAIL fill_usedw %0d: got wr=%0d rd=%0d want %0d", i, bus.wrusedw, bus.rdusedw, (i + 1) % 8);
      end
      checks++;
      if ({bus.wrfull, bus.rdfull, bus.wr_almost_full, bus.rd_almost_full, bus.wrempty}
          !== {(i == 7), (i == 7), (i >= 6), (i >= 6), 1'b0}) begin
        errors++;
        $display("FAIL fill_flags %0d: got %b want %b", i,
                 {bus.wrfull, bus.rdfull, bus.wr_almost_full, bus.rd_almost_full, bus.wrempty},
                 {(i == 7), (i == 7), (i >= 6), (i >= 6), 1'b0});
      end
    end
    bus.data = 8'hAA;
    cyc();
    bus.wrreq = 1'b0;
    checks++;
    if ({bus.wrfull, bus.wrusedw} !== 4'b1000) begin
      errors++;
      $display("FAIL fill_overflow: got full=%b usedw=%0d want 1 0", bus.wrfull, bus.wrusedw);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      bus.rdreq = 1'b1;
      cyc();
      checks++;
      if (bus.q !== 8'(i)) begin
        errors++;
        $display("FAIL drain_q %0d: got %h want %h", i, bus.q, 8'(i));
      end
      checks++;
      if ({bus.rdempty, bus.rdusedw} !== {(i == 7), 3'(7 - i)}) begin
        errors++;
        $display("FAIL drain_status %0d: got empty=%b usedw=%0d want %b %0d", i,
                 bus.rdempty, bus.rdusedw, (i == 7), 7 - i);
      end
    end
    cyc();
    bus.rdreq = 1'b0;
    checks++;
    if (bus.q !== 8'h07 || bus.rdempty !== 1'b1 || bus.rd_almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_underflow: got q=%h empty=%b aempty=%b want 07 1 1", bus.q, bus.rdempty, bus.rd_almost_empty);
    end
  endtask

  task automatic test_paced_stream();
    int  n_wr;
    int  exp_rd;
    logic pend;
    n_wr   = 0;
    exp_rd = 0;
    pend   = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.wrreq = (c % 3 == 0) && (n_wr < 16);
      bus.data  = 8'(n_wr);
      bus.rdreq = ~bus.rdempty;
      if (bus.wrreq) n_wr++;
      cyc();
      if (pend) begin
        checks++;
        if (bus.q !== 8'(exp_rd)) begin
          errors++;
          $display("FAIL paced_q %0d: got %h want %h", exp_rd, bus.q, 8'(exp_rd));
        end
        exp_rd++;
      end
      pend = bus.rdreq;
      if (bus.wrfull || bus.wrusedw > 3'd1) begin
        checks++;
        errors++;
        $display("FAIL paced_count c%0d: got full=%b usedw=%0d want <=1", c, bus.wrfull, bus.wrusedw);
      end
    end
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    checks++;
    if (exp_rd != 16 || bus.rdempty !== 1'b1) begin
      errors++;
      $display("FAIL paced_total: got %0d words empty=%b want 16 1", exp_rd, bus.rdempty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) begin
      bus.wrreq = 1'b1;
      bus.data  = 8'(8'h30 + i);
      cyc();
    end
    bus.rdreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data = 8'(8'h33 + i);
      cyc();
      checks++;
      if (bus.wrusedw !== 3'd3 || bus.q !== 8'(8'h30 + i)) begin
        errors++;
        $display("FAIL simul_mid %0d: got usedw=%0d q=%h want 3 %h", i, bus.wrusedw, bus.q, 8'(8'h30 + i));
      end
    end
    bus.wrreq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (bus.q !== 8'(8'h34 + i)) begin
        errors++;
        $display("FAIL simul_tail %0d: got %h want %h", i, bus.q, 8'(8'h34 + i));
      end
    end
    bus.rdreq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.wrreq = 1'b1;
      bus.data  = 8'(8'h40 + i);
      cyc();
    end
    bus.rdreq = 1'b1;
    bus.data  = 8'h99;
    cyc();
    bus.wrreq = 1'b0;
    checks++;
    if ({bus.wrfull, bus.wrusedw} !== 4'b0111 || bus.q !== 8'h40) begin
      errors++;
      $display("FAIL simul_full: got full=%b usedw=%0d q=%h want 0 7 40", bus.wrfull, bus.wrusedw, bus.q);
    end
    for (int i = 1; i < 8; i++) begin
      cyc();
      checks++;
      if (bus.q !== 8'(8'h40 + i)) begin
        errors++;
        $display("FAIL simul_full_drain %0d: got %h want %h", i, bus.q, 8'(8'h40 + i));
      end
    end
    bus.wrreq = 1'b1;
    bus.data  = 8'h55;
    cyc();
    bus.wrreq = 1'b0;
    checks++;
    if (bus.wrusedw !== 3'd1 || bus.wrempty !== 1'b0 || bus.q !== 8'h47) begin
      errors++;
      $display("FAIL simul_empty: got usedw=%0d empty=%b q=%h want 1 0 47", bus.wrusedw, bus.wrempty, bus.q);
    end
    cyc();
    bus.rdreq = 1'b0;
    checks++;
    if (bus.q !== 8'h55 || bus.rdempty !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty_pop: got q=%h empty=%b want 55 1", bus.q, bus.rdempty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus.wrreq = 1'b1;
      bus.data  = 8'(8'h60 + i);
      cyc();
    end
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b1;
    cyc();
    bus.rdreq = 1'b0;
    checks++;
    if (bus.wrusedw !== 3'd4 || bus.q !== 8'h60) begin
      errors++;
      $display("FAIL rstmid_pre: got usedw=%0d q=%h want 4 60", bus.wrusedw, bus.q);
    end
    #3;
    aclr_n = 1'b0;
    #1;
    checks++;
    if ({bus.wrempty, bus.rdempty, bus.wrusedw, bus.q} !== {2'b11, 3'd0, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_async: got empty=%b%b usedw=%0d q=%h want 11 0 00",
               bus.wrempty, bus.rdempty, bus.wrusedw, bus.q);
    end
    repeat (2) cyc();
    aclr_n = 1'b1;
    cyc();
    bus.wrreq = 1'b1;
    bus.data  = 8'h77;
    cyc();
    bus.data  = 8'h78;
    cyc();
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b1;
    cyc();
    bus.rdreq = 1'b0;
    checks++;
    if (bus.q !== 8'h77 || bus.wrusedw !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_after: got q=%h usedw=%0d want 77 1", bus.q, bus.wrusedw);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_drain();
    test_paced_stream();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
